// File: rtl/mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_arbiter
// Brief    : Round-robin arbiter sharing one 4x4 unsigned multiplier between
//            NUM_REQ requesters, with a one-entry registered result slot.
// Revision : 1.0  initial release
// ============================================================================
module mul_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_c,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          op_count
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [ID_W-1:0] c_LAST_IDX  = ID_W'(NUM_REQ - 1);
    localparam logic [15:0]     c_COUNT_MAX = 16'hFFFF;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [7:0]          r_c;
    logic [ID_W-1:0]     r_id;
    logic [15:0]         r_cnt;

    logic                w_free;
    logic                w_found;
    logic                w_grant;
    logic [ID_W-1:0]     w_gnt_idx;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic [3:0]          w_op_a;
    logic [3:0]          w_op_b;
    logic [7:0]          w_prod;
    logic [NUM_REQ-1:0]  w_ready;
    logic                w_handoff;
    int                  w_dist;
    int                  w_best;

    // Pick the valid requester at the smallest rotational distance from r_ptr.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_best    = NUM_REQ;
        w_dist    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                w_dist = (i + NUM_REQ - int'(r_ptr)) % NUM_REQ;
                if (w_dist < w_best) begin
                    w_best    = w_dist;
                    w_found   = 1'b1;
                    w_gnt_idx = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == ID_W'(i)) begin
                w_op_a = req_a[4*i +: 4];
                w_op_b = req_b[4*i +: 4];
            end
        end
    end

    assign w_prod    = {4'b0000, w_op_a} * {4'b0000, w_op_b};
    assign w_handoff = (r_state == ST_FULL) && rsp_ready;
    assign w_free    = (r_state == ST_EMPTY) || rsp_ready;
    assign w_grant   = w_free && w_found && !rst;
    assign w_ptr_nxt = (w_gnt_idx == c_LAST_IDX) ? '0 : (w_gnt_idx + ID_W'(1));

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = w_grant && (w_gnt_idx == ID_W'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_grant) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (rsp_ready && !w_grant) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result data only moves on a grant, so it holds through backpressure and EMPTY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            r_c   <= '0;
            r_id  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_grant) begin
                r_c   <= w_prod;
                r_id  <= w_gnt_idx;
                r_ptr <= w_ptr_nxt;
            end
            if (w_handoff && (r_cnt != c_COUNT_MAX)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_c     = r_c;
    assign rsp_id    = r_id;
    assign op_count  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_arbiter
// Brief    : Self-checking bench for mul_arbiter against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [4*NUM_REQ-1:0] req_a = '0;
    logic [4*NUM_REQ-1:0] req_b = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [7:0]           rsp_c;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          op_count;

    int checks   = 0;
    int failures = 0;

    // Model state: what the slot must hold after the most recent rising edge.
    int m_valid = 0;
    int m_c     = 0;
    int m_id    = 0;
    int m_cnt   = 0;
    int m_ptr   = 0;

    mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare, then advance the model to the state after the coming rising edge.
    always @(negedge clk) begin
        int g;
        int idx;
        int free;
        int exp_ready;
        if (rst) begin
            m_valid = 0; m_c = 0; m_id = 0; m_cnt = 0; m_ptr = 0;
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_rsp_c", int'(rsp_c), 0);
            chk("rst_rsp_id", int'(rsp_id), 0);
            chk("rst_op_count", int'(op_count), 0);
        end else begin
            free = (m_valid == 0 || rsp_ready) ? 1 : 0;
            g = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            exp_ready = (free == 1 && g >= 0) ? (1 << g) : 0;
            chk("model_req_ready", int'(req_ready), exp_ready);
            chk("model_rsp_valid", int'(rsp_valid), m_valid);
            chk("model_rsp_c", int'(rsp_c), m_c);
            chk("model_rsp_id", int'(rsp_id), m_id);
            chk("model_op_count", int'(op_count), m_cnt);
            if (m_valid == 1 && rsp_ready && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (free == 1 && g >= 0) begin
                m_c     = int'(req_a[4*g +: 4]) * int'(req_b[4*g +: 4]);
                m_id    = g;
                m_valid = 1;
                m_ptr   = (g + 1) % NUM_REQ;
            end else if (m_valid == 1 && rsp_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'hE1; exp_seq[1] = 8'h0F; exp_seq[2] = 8'hE1; exp_seq[3] = 8'h0F;

        // Single request
        do_reset();
        req_valid = 2'b01; req_a[3:0] = 4'd7; req_b[3:0] = 4'd9; rsp_ready = 1'b1;
        @(negedge clk);
        chk("single_ready", int'(req_ready), 1);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("single_valid", int'(rsp_valid), 1);
        chk("single_c", int'(rsp_c), 8'h3F);
        chk("single_id", int'(rsp_id), 0);
        next_cycle();
        @(negedge clk);
        chk("single_count", int'(op_count), 1);

        // Backpressure
        next_cycle();
        req_valid = 2'b01; rsp_ready = 1'b0;
        next_cycle();
        req_valid = 2'b11; req_a[7:4] = 4'd3; req_b[7:4] = 4'd5;
        repeat (5) begin
            @(negedge clk);
            chk("bp_ready", int'(req_ready), 0);
            chk("bp_c", int'(rsp_c), 8'h3F);
            chk("bp_id", int'(rsp_id), 0);
            chk("bp_count", int'(op_count), 1);
            next_cycle();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", int'(req_ready), 2);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("bp_next_c", int'(rsp_c), 8'h0F);
        chk("bp_next_id", int'(rsp_id), 1);
        chk("bp_next_count", int'(op_count), 2);

        // Operand boundaries and exhaustive sweep on the last requester
        next_cycle();
        req_valid = 2'b10; req_a[7:4] = 4'd0; req_b[7:4] = 4'd15;
        next_cycle();
        req_a[7:4] = 4'd15; req_b[7:4] = 4'd15;
        @(negedge clk);
        chk("bound_zero", int'(rsp_c), 8'h00);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("bound_max", int'(rsp_c), 8'hE1);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                next_cycle();
                req_valid = 2'b10; req_a[7:4] = 4'(a); req_b[7:4] = 4'(b);
            end
        end
        next_cycle();
        req_valid = '0;

        // Asynchronous reset while a result is held, then contention
        next_cycle();
        req_valid = 2'b01; req_a[3:0] = 4'd7; req_b[3:0] = 4'd9; rsp_ready = 1'b0;
        next_cycle();
        req_valid = 2'b11;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", int'(rsp_valid), 0);
        chk("arst_c", int'(rsp_c), 0);
        chk("arst_count", int'(op_count), 0);
        next_cycle();
        rst = 1'b0;
        req_valid = 2'b11; req_a = {4'd3, 4'd15}; req_b = {4'd5, 4'd15}; rsp_ready = 1'b1;
        @(negedge clk);
        chk("arst_first_grant", int'(req_ready), 1);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge clk);
            chk("cont_c", int'(rsp_c), int'(exp_seq[k]));
            chk("cont_id", int'(rsp_id), k % 2);
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            req_valid = NUM_REQ'($urandom);
            req_a     = (4*NUM_REQ)'($urandom);
            req_b     = (4*NUM_REQ)'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end

        // Handoff counter saturation
        do_reset();
        req_valid = 2'b01; req_a[3:0] = 4'd1; req_b[3:0] = 4'd1; rsp_ready = 1'b1;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        chk("sat_count", int'(op_count), 16'hFFFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sat_hold", int'(op_count), 16'hFFFF);

        next_cycle();
        req_valid = '0;
        rsp_ready = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing the 4x4 multiplier (legal 2..8).
REQ-002 Parameter ID_W, default 1, width of the requester index; SHALL equal max(1, clog2(NUM_REQ)).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  NUM_REQ  bit i high = requester i presents an operand pair.
REQ-006 req_a  input  4*NUM_REQ  operand a; requester i at bits [4i+3:4i], unsigned.
REQ-007 req_b  input  4*NUM_REQ  operand b; requester i at bits [4i+3:4i], unsigned.
REQ-008 req_ready  output  NUM_REQ  bit i high = requester i's pair accepted this cycle.
REQ-009 rsp_valid  output  1  result slot holds a valid product.
REQ-010 rsp_ready  input  1  consumer accepts the result this cycle.
REQ-011 rsp_c  output  8  registered product a*b, unsigned.
REQ-012 rsp_id  output  ID_W  index of the requester that owns rsp_c.
REQ-013 op_count  output  16  number of completed handoffs (rsp_valid && rsp_ready).

Function
REQ-014 Single one-entry result slot; two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-015 Slot is "free" when state is EMPTY, or FULL with rsp_ready=1 in the same cycle.
REQ-016 When free and any req_valid is high, exactly one requester SHALL be granted, chosen round-robin.
REQ-017 Round-robin: search starts at pointer p and wraps modulo NUM_REQ; the first valid index wins.
REQ-018 After a grant to index g, p SHALL become (g+1) mod NUM_REQ; p SHALL be unchanged when there is no grant.
REQ-019 req_ready is combinational: req_ready[g]=1 only for the granted index; all other bits are 0; at most one bit is high.
REQ-020 req_ready SHALL be all zero when the slot is not free, regardless of req_valid.
REQ-021 On a grant at edge k, rsp_c=a_g*b_g (full 8-bit, no truncation) and rsp_id=g are loaded, and rsp_valid=1 after edge k (latency 1 cycle).
REQ-022 FULL with rsp_ready=0: rsp_c, rsp_id and rsp_valid SHALL hold stable.
REQ-023 FULL with rsp_ready=1 and a new grant: the slot is reloaded at the same edge and rsp_valid stays 1 (back-to-back, one result per cycle).
REQ-024 FULL with rsp_ready=1 and no grant: transition to EMPTY; rsp_c and rsp_id hold their last values.
REQ-025 rsp_ready while EMPTY SHALL be ignored, with no count change.
REQ-026 op_count increments by 1 on each edge where rsp_valid && rsp_ready, and saturates at 0xFFFF.
REQ-027 Requesters holding req_valid without req_ready keep their operands stable; the block does not latch unaccepted data.

Reset
REQ-028 rst=1 SHALL immediately (asynchronously) force rsp_valid=0, rsp_c=0x00, rsp_id=0, op_count=0, p=0 and state EMPTY.
REQ-029 req_ready SHALL be all zero while rst=1.
REQ-030 Reset mid-operation SHALL discard any held result with no handoff counted; the first grant after release starts the search at index 0.

Verification
REQ-031 Single request: req_valid=01, a0=7, b0=9, rsp_ready=1 -> req_ready=01 that cycle; next cycle rsp_valid=1, rsp_c=0x3F, rsp_id=0; op_count=1 after the handoff.
REQ-032 Contention, NUM_REQ=2: both valid continuously, a0=b0=15, a1=3, b1=5, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_c alternates 0xE1,0x0F at one result per cycle.
REQ-033 Backpressure: result 0x3F held with rsp_ready=0 for 5 cycles while req_valid=11 -> req_ready=00; rsp_c/rsp_id stable; op_count unchanged; on rsp_ready=1, handoff and next grant occur at the same edge.
REQ-034 Boundaries: a=0,b=15 -> 0x00; a=15,b=15 -> 0xE1; exhaustive 256 operand pairs through requester NUM_REQ-1 match a*b.
REQ-035 Reset mid-operation: assert rst while rsp_valid=1, asynchronously between edges -> rsp_valid=0 and rsp_c=0 before the next edge; op_count=0; first post-reset grant with req_valid=11 goes to index 0.
REQ-036 Saturation: preload 0xFFFE handoffs (or force op_count), perform 3 handoffs -> op_count=0xFFFF and stays there.
